// File: rtl/pc_controller.sv
// rtl/pc_controller.sv - fetch-stage program-counter sequencer
//
// Purpose:
//   Owns the fetch PC. Each cycle it selects PC+4, a branch target, a jump
//   target, the trap vector, or holds. Issues fetch requests with a
//   valid/ready handshake, pulses flush_o on every redirect and flags
//   misaligned redirect targets (which are replaced by TRAP_VECTOR).
//
// Optional feature macro: PC_CTRL_PERF_CNT_EN
//   When defined, adds fetch_cnt_o / redirect_cnt_o performance counters.
//
// Ports:
//   clk              in   rising-edge clock
//   rst_n            in   asynchronous active-low reset
//   stall_i          in   hazard stall: hold PC, withdraw request
//   trap_i           in   redirect to TRAP_VECTOR (highest priority)
//   branch_taken_i   in   taken branch from EX
//   branch_target_i  in   [63:0] branch target
//   jump_i           in   JAL/JALR resolved (lowest priority)
//   jump_target_i    in   [63:0] jump target
//   imem_ready_i     in   instruction memory accepts the request
//   pc_o             out  [63:0] current fetch address
//   pc_valid_o       out  fetch request valid
//   flush_o          out  one-cycle IF/ID flush, aligned with redirected pc_o
//   misalign_o       out  one-cycle misaligned-target flag
//   fetch_cnt_o      out  [63:0] accepted fetches (PC_CTRL_PERF_CNT_EN only)
//   redirect_cnt_o   out  [31:0] redirects taken (PC_CTRL_PERF_CNT_EN only)

module pc_controller #(
  parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_0000_0000,
  parameter logic [63:0] TRAP_VECTOR  = 64'h0000_0000_0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        trap_i,
  input  logic        branch_taken_i,
  input  logic [63:0] branch_target_i,
  input  logic        jump_i,
  input  logic [63:0] jump_target_i,
  input  logic        imem_ready_i,
`ifdef PC_CTRL_PERF_CNT_EN
  output logic [63:0] fetch_cnt_o,
  output logic [31:0] redirect_cnt_o,
`endif
  output logic [63:0] pc_o,
  output logic        pc_valid_o,
  output logic        flush_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  state_e      state_q;
  logic [63:0] pc_q;
  logic        valid_q;
  logic        flush_q;
  logic        misalign_q;

  // Redirect decode: priority select, then misalignment substitution.
  logic        redir_req;
  logic        redir_d;
  logic [63:0] sel_target;
  logic        misalign_d;
  logic [63:0] redir_pc_d;

  always_comb begin
    redir_req  = trap_i | branch_taken_i | jump_i;
    sel_target = jump_target_i;
    if (trap_i) begin
      sel_target = TRAP_VECTOR;
    end else if (branch_taken_i) begin
      sel_target = branch_target_i;
    end
    // The trap vector itself is never reported as misaligned.
    misalign_d = redir_req & ~trap_i & (sel_target[1:0] != 2'b00);
    redir_pc_d = misalign_d ? TRAP_VECTOR : sel_target;
    // Redirects arriving while still in BOOT are dropped.
    redir_d    = redir_req & (state_q != ST_BOOT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        ST_BOOT: begin
          state_q <= ST_RUN;
          valid_q <= 1'b1;
        end
        ST_RUN, ST_STALL: begin
          if (redir_d) begin
            // Redirect wins over stall and abandons any outstanding request.
            state_q    <= ST_RUN;
            pc_q       <= redir_pc_d;
            valid_q    <= 1'b1;
            flush_q    <= 1'b1;
            misalign_q <= misalign_d;
          end else if (stall_i) begin
            state_q <= ST_STALL;
            valid_q <= 1'b0;
          end else begin
            state_q <= ST_RUN;
            valid_q <= 1'b1;
            // Leaving STALL re-presents the held PC; only RUN advances.
            if ((state_q == ST_RUN) && imem_ready_i) begin
              pc_q <= pc_q + 64'd4;
            end
          end
        end
        default: begin
          state_q <= ST_BOOT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o       = pc_q;
  assign pc_valid_o = valid_q;
  assign flush_o    = flush_q;
  assign misalign_o = misalign_q;

`ifdef PC_CTRL_PERF_CNT_EN
  logic [63:0] fetch_cnt_q;
  logic [31:0] redirect_cnt_q;
  logic        fetch_accept;

  assign fetch_accept = valid_q & imem_ready_i & ~stall_i & ~redir_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q    <= 64'd0;
      redirect_cnt_q <= 32'd0;
    end else begin
      if (fetch_accept) begin
        fetch_cnt_q <= fetch_cnt_q + 64'd1;
      end
      if (redir_d) begin
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt_o    = fetch_cnt_q;
  assign redirect_cnt_o = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_pc_controller.sv
// tb/tb_pc_controller.sv - directed self-checking bench for pc_controller

module tb_pc_controller;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        trap_i;
  logic        branch_taken_i;
  logic [63:0] branch_target_i;
  logic        jump_i;
  logic [63:0] jump_target_i;
  logic        imem_ready_i;
  logic [63:0] pc_o;
  logic        pc_valid_o;
  logic        flush_o;
  logic        misalign_o;
`ifdef PC_CTRL_PERF_CNT_EN
  logic [63:0] fetch_cnt_o;
  logic [31:0] redirect_cnt_o;
  logic [31:0] rc_before;
  logic [63:0] fc_before;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pc_controller dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .trap_i          (trap_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .imem_ready_i    (imem_ready_i),
`ifdef PC_CTRL_PERF_CNT_EN
    .fetch_cnt_o     (fetch_cnt_o),
    .redirect_cnt_o  (redirect_cnt_o),
`endif
    .pc_o            (pc_o),
    .pc_valid_o      (pc_valid_o),
    .flush_o         (flush_o),
    .misalign_o      (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redir();
    trap_i = 1'b0;
    branch_taken_i = 1'b0;
    jump_i = 1'b0;
  endtask

  // Check pc/valid/flush/misalign together.
  task automatic expect_state(input string tag, input logic [63:0] pc, input logic v,
                              input logic fl, input logic ma);
    check({tag, ".pc"}, pc_o, pc);
    check({tag, ".valid"}, {63'd0, pc_valid_o}, {63'd0, v});
    check({tag, ".flush"}, {63'd0, flush_o}, {63'd0, fl});
    check({tag, ".misalign"}, {63'd0, misalign_o}, {63'd0, ma});
  endtask

  initial begin
    rst_n = 1'b0;
    stall_i = 1'b0;
    clear_redir();
    branch_target_i = 64'd0;
    jump_target_i = 64'd0;
    imem_ready_i = 1'b0;

    step();
    step();
    expect_state("reset", 64'h0, 1'b0, 1'b0, 1'b0);

    // Release reset; BOOT edge, then first request at RESET_VECTOR.
    rst_n = 1'b1;
    imem_ready_i = 1'b1;
    step();
    expect_state("boot_exit", 64'h0, 1'b1, 1'b0, 1'b0);
    step();
    check("seq1", pc_o, 64'h4);
    step();
    check("seq2", pc_o, 64'h8);

    // Not-ready hold at 0x8.
    imem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_state("hold", 64'h8, 1'b1, 1'b0, 1'b0);
    end
    imem_ready_i = 1'b1;
    step();
    check("after_hold", pc_o, 64'hC);
    step();
    check("seq_10", pc_o, 64'h10);
    step();
    step();
    step();
    step();
    check("seq_20", pc_o, 64'h20);

    // All three redirects at once: trap wins.
    trap_i = 1'b1;
    branch_taken_i = 1'b1;
    branch_target_i = 64'h400;
    jump_i = 1'b1;
    jump_target_i = 64'h800;
    step();
    expect_state("trap_prio", 64'h100, 1'b1, 1'b1, 1'b0);
    clear_redir();
    step();
    expect_state("after_trap", 64'h104, 1'b1, 1'b0, 1'b0);

    // Misaligned branch target.
`ifdef PC_CTRL_PERF_CNT_EN
    rc_before = redirect_cnt_o;
`endif
    branch_taken_i = 1'b1;
    branch_target_i = 64'h402;
    step();
    expect_state("misalign", 64'h100, 1'b1, 1'b1, 1'b1);
`ifdef PC_CTRL_PERF_CNT_EN
    check("redirect_cnt", {32'd0, redirect_cnt_o}, {32'd0, rc_before + 32'd1});
`endif
    clear_redir();
    step();
    expect_state("after_misalign", 64'h104, 1'b1, 1'b0, 1'b0);

    // Branch beats jump when no trap.
    branch_taken_i = 1'b1;
    branch_target_i = 64'h30;
    jump_i = 1'b1;
    jump_target_i = 64'h700;
    step();
    expect_state("branch_prio", 64'h30, 1'b1, 1'b1, 1'b0);
    clear_redir();

    // Stall two cycles at 0x30, then jump during stall.
    stall_i = 1'b1;
    step();
    expect_state("stall1", 64'h30, 1'b0, 1'b0, 1'b0);
    step();
    expect_state("stall2", 64'h30, 1'b0, 1'b0, 1'b0);
    jump_i = 1'b1;
    jump_target_i = 64'h60;
    imem_ready_i = 1'b0;
    step();
    expect_state("stall_jump", 64'h60, 1'b1, 1'b1, 1'b0);
    clear_redir();
    step();
    expect_state("post_stall_jump", 64'h60, 1'b0, 1'b0, 1'b0);

    // Stall release without redirect re-presents the held PC.
    stall_i = 1'b0;
    imem_ready_i = 1'b1;
    step();
    expect_state("unstall", 64'h60, 1'b1, 1'b0, 1'b0);
    step();
    check("unstall_adv", pc_o, 64'h64);

    // Back-to-back redirects keep flush high.
    branch_taken_i = 1'b1;
    branch_target_i = 64'h200;
    step();
    expect_state("b2b_1", 64'h200, 1'b1, 1'b1, 1'b0);
    clear_redir();
    jump_i = 1'b1;
    jump_target_i = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    expect_state("b2b_2", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1, 1'b0);
    clear_redir();

    // Wrap at top of address space.
`ifdef PC_CTRL_PERF_CNT_EN
    fc_before = fetch_cnt_o;
`endif
    step();
    expect_state("wrap", 64'h0, 1'b1, 1'b0, 1'b0);
`ifdef PC_CTRL_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt_o, fc_before + 64'd1);
`endif
    step();
    check("wrap_adv", pc_o, 64'h4);

    // Asynchronous reset mid-run, checked between edges.
    #2;
    rst_n = 1'b0;
    #1;
    expect_state("async_rst", 64'h0, 1'b0, 1'b0, 1'b0);
    step();

    // Redirect presented across BOOT is ignored.
    jump_i = 1'b1;
    jump_target_i = 64'h500;
    rst_n = 1'b1;
    step();
    expect_state("boot_redir", 64'h0, 1'b1, 1'b0, 1'b0);
    clear_redir();
    step();
    check("boot_redir_adv", pc_o, 64'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
